game_status_ctrl: RTL
=====================

Name: game_status_ctrl

Overview:
- Downstream aggregator for the per-enemy gamelogic instances.
- Combines the per-enemy cumulative damage, score and alive flags into player blood, total score, high score, alive-enemy count and a hit-flash indicator.
- Runs the top-level game-state FSM (IDLE/START/PLAY/PAUSE/OVER).
- Issues the one-clock gameplay reset pulse and the run-enable that gates the gameplay frame tick.

Parameters:
- ENEMY_NUM, 4: number of gamelogic instances aggregated.
- PLAYER_FULL_BLOOD, 100: player blood at game start (7-bit).
- FLASH_FRAMES, 8: frames Hit_Flash stays high after damage.
- OVER_LOCK_FRAMES, 60: minimum frames in OVER before Start_Key is accepted.

Ports:
- Clk, in, 1: system clock.
- Reset, in, 1: synchronous, active-high reset.
- game_frame_clk_rising_edge, in, 1: one-Clk pulse per video frame.
- Start_Key, in, 1: level from the keyboard decoder; edge-detected internally.
- Pause_Key, in, 1: level; edge-detected internally.
- Enemy_Total_Damage_Bus, in, 10*ENEMY_NUM: cumulative damage of enemy i at [10i+9:10i].
- Score_Bus, in, 8*ENEMY_NUM: score of enemy i at [8i+7:8i].
- Enemy_Alive_Bus, in, ENEMY_NUM: alive flag of enemy i.
- Game_State, out, 3: 0 IDLE, 1 START, 2 PLAY, 3 PAUSE, 4 OVER.
- Game_Reset, out, 1: one-Clk pulse that resets all gamelogic/enemy/player instances.
- Game_Run, out, 1: high only in PLAY; ANDed with the frame tick feeding gameplay blocks.
- Player_Blood, out, 7: remaining player blood.
- Total_Score, out, 10: sum of the enemy scores.
- High_Score, out, 10: best Total_Score since Reset.
- Alive_Count, out, 3: number of alive enemies.
- Hit_Flash, out, 1: high while the player damage flash is active.

Behaviour:
- Reset values:
  - State IDLE, Game_Reset 0, Game_Run 0.
  - Player_Blood = PLAYER_FULL_BLOOD.
  - Total_Score, High_Score, Alive_Count = 0.
  - Hit_Flash 0, flash and lock counters 0, key edge registers 0.
- Key edges: each key is registered once per Clk. A press is the current level 1 while the registered level is 0. A key held through reset does not produce a press on the first cycle after reset.
- Damage sum: combinational 12-bit sum of all 10-bit fields (max 4092, no overflow).
- Player blood: raw value is PLAYER_FULL_BLOOD − sum, saturating to 0 when sum ≥ PLAYER_FULL_BLOOD. It is registered every Clk (1-cycle latency) in PLAY only. It holds in PAUSE and OVER and is forced to full in IDLE and START.
- Total_Score: 10-bit sum of the score fields, registered every Clk in all states (1-cycle latency).
- Alive_Count: popcount of Enemy_Alive_Bus, registered every Clk.
- FSM transitions:
  - IDLE → START on a Start_Key press.
  - START lasts exactly 1 Clk with Game_Reset=1, then goes to PLAY.
  - PLAY → OVER on a Clk where game_frame_clk_rising_edge=1 and the registered Player_Blood==0.
  - PLAY → PAUSE on a Pause_Key press.
  - PAUSE → PLAY on a Pause_Key press.
  - PAUSE → START on a Start_Key press (restart).
  - OVER → START on a Start_Key press, only once the lock counter has reached OVER_LOCK_FRAMES.
- Simultaneous presses in PLAY: Pause wins, and Start is ignored in PLAY.
- Lock counter: cleared on OVER entry and incremented on each frame tick while in OVER, saturating at OVER_LOCK_FRAMES. A Start_Key press before the lock expires is dropped, not queued.
- High_Score: on the PLAY→OVER transition Clk, High_Score ← Total_Score if Total_Score > High_Score. It is unaffected by Game_Reset and cleared only by Reset.
- Hit detection: a prior-sum register stores the damage sum each Clk. In PLAY, if sum > prior-sum, the flash counter loads FLASH_FRAMES. A new hit while the flash is active reloads the counter (no accumulation).
- Flash counter: decrements on each frame tick while non-zero. Hit_Flash = (counter ≠ 0).
- Flash on state changes: the counter is cleared in START and on OVER entry.
- Prior-sum during START: the prior-sum register loads 0 in START, so the post-reset drop in the sum never registers as a hit.
- Reset mid-game: returns to IDLE next Clk with all reset values.

Test Plan:
- Reset, Start_Key pulse → Game_State IDLE→START (Game_Reset=1 for exactly 1 Clk)→PLAY; Game_Run=1; Player_Blood=100.
- In PLAY, enemy 0 damage 0→10 then enemy 2 damage 0→30 → Player_Blood 90 then 60 one Clk after each change; Hit_Flash high for 8 frame ticks after each hit, reloaded by the second hit.
- Damage sum reaches 120 with scores 3, 5, 0, 2 → Player_Blood=0; OVER on the next frame tick; Total_Score=10; High_Score 0→10; Game_Run=0.
- In OVER, Start_Key press at frame 30 → ignored; press at frame 61 → START pulse; High_Score stays 10 after the Game_Reset pulse.
- In PLAY, Pause_Key press → PAUSE; damage change 0→50 while paused → Player_Blood holds. Second Pause_Key press → PLAY; blood updates to 50 next Clk.
- Start_Key held high across Reset release → stays IDLE; Enemy_Alive_Bus=4'b1011 → Alive_Count=3 one Clk later.

Source files
------------

// File: rtl/game_status_ctrl.sv
// Game-level status aggregator: combines per-enemy damage, score and alive
// flags, and runs the IDLE/START/PLAY/PAUSE/OVER state machine.
module game_status_ctrl #(
  parameter int ENEMY_NUM         = 4,
  parameter int PLAYER_FULL_BLOOD = 100,
  parameter int FLASH_FRAMES      = 8,
  parameter int OVER_LOCK_FRAMES  = 60
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    game_frame_clk_rising_edge,
  input  logic                    Start_Key,
  input  logic                    Pause_Key,
  input  logic [10*ENEMY_NUM-1:0] Enemy_Total_Damage_Bus,
  input  logic [8*ENEMY_NUM-1:0]  Score_Bus,
  input  logic [ENEMY_NUM-1:0]    Enemy_Alive_Bus,
  output logic [2:0]              Game_State,
  output logic                    Game_Reset,
  output logic                    Game_Run,
  output logic [6:0]              Player_Blood,
  output logic [9:0]              Total_Score,
  output logic [9:0]              High_Score,
  output logic [2:0]              Alive_Count,
  output logic                    Hit_Flash
);

  localparam int LW = $clog2(OVER_LOCK_FRAMES + 1);
  localparam int FW = $clog2(FLASH_FRAMES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t state, state_n;

  logic start_q, pause_q, armed;
  logic start_press, pause_press;
  logic frame;
  logic [11:0] dmg_sum, prior_sum;
  logic [9:0] score_sum;
  logic [2:0] alive_sum;
  logic [6:0] raw_blood;
  logic [LW-1:0] lock_cnt;
  logic [FW-1:0] flash_cnt;
  logic over_entry, lock_done;

  // armed blocks a press on the first cycle out of reset for held keys
  assign start_press = Start_Key & ~start_q & armed;
  assign pause_press = Pause_Key & ~pause_q & armed;
  assign frame       = game_frame_clk_rising_edge;
  assign lock_done   = (lock_cnt == LW'(OVER_LOCK_FRAMES));

  always_comb begin
    dmg_sum   = '0;
    score_sum = '0;
    alive_sum = '0;
    for (int i = 0; i < ENEMY_NUM; i++) begin
      dmg_sum   = dmg_sum + 12'(Enemy_Total_Damage_Bus[10*i +: 10]);
      score_sum = score_sum + 10'(Score_Bus[8*i +: 8]);
      alive_sum = alive_sum + 3'(Enemy_Alive_Bus[i]);
    end
  end

  always_comb begin
    raw_blood = '0;
    if (dmg_sum < 12'(PLAYER_FULL_BLOOD))
      raw_blood = 7'(12'(PLAYER_FULL_BLOOD) - dmg_sum);
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (start_press) state_n = S_START;
      S_START: state_n = S_PLAY;
      S_PLAY: begin
        if (frame && Player_Blood == 7'd0) state_n = S_OVER;
        else if (pause_press)              state_n = S_PAUSE;
      end
      S_PAUSE: begin
        if (pause_press)      state_n = S_PLAY;
        else if (start_press) state_n = S_START;
      end
      S_OVER:  if (start_press && lock_done) state_n = S_START;
      default: state_n = S_IDLE;
    endcase
  end

  assign over_entry = (state == S_PLAY) && (state_n == S_OVER);
  assign Game_State = state;
  assign Game_Reset = (state == S_START);
  assign Game_Run   = (state == S_PLAY);
  assign Hit_Flash  = (flash_cnt != '0);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= S_IDLE;
      start_q      <= 1'b0;
      pause_q      <= 1'b0;
      armed        <= 1'b0;
      Player_Blood <= 7'(PLAYER_FULL_BLOOD);
      Total_Score  <= '0;
      High_Score   <= '0;
      Alive_Count  <= '0;
      prior_sum    <= '0;
      lock_cnt     <= '0;
      flash_cnt    <= '0;
    end else begin
      state       <= state_n;
      start_q     <= Start_Key;
      pause_q     <= Pause_Key;
      armed       <= 1'b1;
      Total_Score <= score_sum;
      Alive_Count <= alive_sum;
      prior_sum   <= (state == S_START) ? 12'd0 : dmg_sum;

      if (state == S_IDLE || state == S_START)
        Player_Blood <= 7'(PLAYER_FULL_BLOOD);
      else if (state == S_PLAY)
        Player_Blood <= raw_blood;

      if (over_entry && Total_Score > High_Score)
        High_Score <= Total_Score;

      if (over_entry)
        lock_cnt <= '0;
      else if (state == S_OVER && frame && !lock_done)
        lock_cnt <= lock_cnt + 1'b1;

      // state changes win over a coincident hit
      if (state == S_START || over_entry)
        flash_cnt <= '0;
      else if (state == S_PLAY && dmg_sum > prior_sum)
        flash_cnt <= FW'(FLASH_FRAMES);
      else if (frame && flash_cnt != '0)
        flash_cnt <= flash_cnt - 1'b1;
    end
  end

endmodule
